// File: rtl/echo_delay_proc_pkg.sv
// Shared types and constants for the echo delay processor.
// Holds the FSM state encoding, sample/internal widths and saturation limits,
// plus the clipping helper used by the CALC step.
package echo_delay_proc_pkg;

  localparam int SAMPLE_W = 10;  // ADC/DAC sample width, offset binary
  localparam int X_W      = 11;  // signed input after offset removal
  localparam int Y_W      = 12;  // signed sum of input and half echo

  localparam logic signed [Y_W-1:0] Y_MAX = 12'sd511;
  localparam logic signed [Y_W-1:0] Y_MIN = -12'sd512;

  localparam logic [SAMPLE_W-1:0] MID_CODE = 10'd512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CALC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  // Clipped sample in two's complement plus a flag saying clipping happened.
  typedef struct packed {
    logic                clip;
    logic [SAMPLE_W-1:0] val;
  } calc_t;

  function automatic calc_t saturate(input logic signed [Y_W-1:0] y);
    calc_t r;
    if (y > Y_MAX) begin
      r.clip = 1'b1;
      r.val  = 10'h1FF;
    end else if (y < Y_MIN) begin
      r.clip = 1'b1;
      r.val  = 10'h200;
    end else begin
      r.clip = 1'b0;
      r.val  = y[SAMPLE_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/echo_delay_proc_if.sv
// Sample bus between the ADC stage, the echo processor and the DAC stage.
// master: drives data_in/data_valid/delay/echo_en, receives data_out/out_valid/sat.
// slave : the processor side of the same signals.
interface echo_delay_proc_if
  import echo_delay_proc_pkg::*;
#(
  parameter int DEPTH_LOG2 = 13
);
  logic [SAMPLE_W-1:0]   data_in;
  logic                  data_valid;
  logic [DEPTH_LOG2-1:0] delay;
  logic                  echo_en;
  logic [SAMPLE_W-1:0]   data_out;
  logic                  out_valid;
  logic                  sat;

  modport master (
    output data_in, data_valid, delay, echo_en,
    input  data_out, out_valid, sat
  );

  modport slave (
    input  data_in, data_valid, delay, echo_en,
    output data_out, out_valid, sat
  );
endinterface

// File: rtl/echo_delay_proc_delay_ram.sv
// Delay line storage: single-port synchronous RAM with registered read data.
// Ports: clk, we, addr (shared by read and write), wdata, rdata (valid the cycle after addr).
// No reset, so it maps onto block RAM; read-before-write on a shared address.
module delay_ram #(
  parameter int AW = 13,
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/echo_delay_proc.sv
// Feedback echo processor: y = (data_in - OFFSET) + (delayed y)/2, clipped to 10 bits.
// Ports: sysclk, rst_n (async, active-low), bus (slave side of echo_delay_proc_if).
// Latency 3 cycles strobe-to-out_valid; strobes arriving while busy are dropped, not queued.
module echo_delay_proc
  import echo_delay_proc_pkg::*;
#(
  parameter int                  DEPTH_LOG2 = 13,
  parameter logic [SAMPLE_W-1:0] OFFSET     = 10'd512
) (
  input  logic              sysclk,
  input  logic              rst_n,
  echo_delay_proc_if.slave  bus
);

  localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  state_t                state;
  logic [SAMPLE_W-1:0]   din_q;
  logic [DEPTH_LOG2-1:0] delay_q;
  logic                  echo_q;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2:0]   fill;     // samples written since reset, saturating at DEPTH
  logic [SAMPLE_W-1:0]   y_q;      // clipped result, two's complement
  logic                  sat_q;
  logic [SAMPLE_W-1:0]   data_out_q;
  logic                  out_valid_q;
  logic                  sat_out_q;

  // RAM port is time-shared: the read address is only needed in READ,
  // the write address only in WRITE.
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic                  ram_we;
  logic [SAMPLE_W-1:0]   ram_rdata;

  assign rd_addr  = wr_ptr - delay_q;  // wraps modulo the depth
  assign ram_addr = (state == WRITE) ? wr_ptr : rd_addr;
  assign ram_we   = (state == WRITE);

  delay_ram #(
    .AW (DEPTH_LOG2),
    .DW (SAMPLE_W)
  ) u_delay_ram (
    .clk   (sysclk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (y_q),
    .rdata (ram_rdata)
  );

  // CALC datapath. A delay code of 0 means a full-depth delay, so the echo is
  // only trusted once that many samples have been written since reset.
  logic [DEPTH_LOG2:0]          eff_delay;
  logic                         use_echo;
  logic signed [X_W-1:0]        x;
  logic signed [SAMPLE_W-1:0]   e;
  logic signed [SAMPLE_W-1:0]   e_half;
  logic signed [Y_W-1:0]        y;
  calc_t                        calc;

  assign eff_delay = (delay_q == '0) ? DEPTH : {1'b0, delay_q};
  assign use_echo  = echo_q && (fill >= eff_delay);
  assign x         = $signed({1'b0, din_q}) - $signed({1'b0, OFFSET});
  assign e         = use_echo ? $signed(ram_rdata) : '0;
  assign e_half    = e >>> 1;  // arithmetic: rounds toward minus infinity
  assign y         = $signed({x[X_W-1], x}) +
                     $signed({{(Y_W-SAMPLE_W){e_half[SAMPLE_W-1]}}, e_half});
  assign calc      = saturate(y);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      din_q       <= '0;
      delay_q     <= '0;
      echo_q      <= 1'b0;
      wr_ptr      <= '0;
      fill        <= '0;
      y_q         <= '0;
      sat_q       <= 1'b0;
      data_out_q  <= MID_CODE;
      out_valid_q <= 1'b0;
      sat_out_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      sat_out_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.data_valid) begin
            din_q   <= bus.data_in;
            delay_q <= bus.delay;
            echo_q  <= bus.echo_en;
            state   <= READ;
          end
        end
        READ: begin
          state <= CALC;
        end
        CALC: begin
          y_q   <= calc.val;
          sat_q <= calc.clip;
          state <= WRITE;
        end
        WRITE: begin
          wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
          if (fill != DEPTH) begin
            fill <= fill + (DEPTH_LOG2+1)'(1);
          end
          // Adding mid-scale to a 10-bit two's complement value flips the MSB.
          data_out_q  <= {~y_q[SAMPLE_W-1], y_q[SAMPLE_W-2:0]};
          out_valid_q <= 1'b1;
          sat_out_q   <= sat_q;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sat       = sat_out_q;

endmodule

// File: tb/tb_echo_delay_proc.sv
// Self-checking bench for echo_delay_proc at DEPTH_LOG2=4.
// Directed scenarios then randomized samples against a history-based reference model.
// Ports: none; drives the DUT through an echo_delay_proc_if instance.
module tb_echo_delay_proc;

  localparam int DL = 4;
  localparam int DEPTH = 16;

  logic sysclk;
  logic rst_n;

  echo_delay_proc_if #(.DEPTH_LOG2(DL)) bus ();

  echo_delay_proc #(
    .DEPTH_LOG2 (DL),
    .OFFSET     (10'd512)
  ) dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int tests;
  int failures;
  int hist[$];  // clipped values written since the last reset, oldest first

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: y = (din - 512) + floor(echo / 2), echo being the value written
  // d samples ago (d = 16 for a delay code of 0) when enough history exists.
  task automatic model_step(input int din, input int dly, input int en,
                            output int exp_out, output int exp_sat);
    int d, k, e, half, y;
    d = (dly == 0) ? DEPTH : dly;
    k = hist.size();
    e = (en != 0 && k >= d) ? hist[k-d] : 0;
    half = (e >= 0) ? e / 2 : -((1 - e) / 2);
    y = (din - 512) + half;
    exp_sat = 0;
    if (y > 511) begin y = 511; exp_sat = 1; end
    if (y < -512) begin y = -512; exp_sat = 1; end
    hist.push_back(y);
    exp_out = y + 512;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.data_valid = 1'b0;
    @(negedge sysclk);
    check("rst_data_out", bus.data_out, 512);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sat", bus.sat, 0);
    @(negedge sysclk);
    rst_n = 1'b1;
    hist.delete();
    @(negedge sysclk);
  endtask

  // Strobe one sample (caller sits at a negedge) and wait for its result.
  task automatic send(input string tag, input int din, input int dly, input int en,
                      output int got, output int got_sat);
    int exp_out, exp_sat, lat;
    logic [9:0] d10;
    logic [DL-1:0] dd;
    d10 = din[9:0];
    dd = dly[DL-1:0];
    bus.data_in = d10;
    bus.delay = dd;
    bus.echo_en = en[0];
    bus.data_valid = 1'b1;
    model_step(din, dly, en, exp_out, exp_sat);
    lat = -1;
    got = -1;
    got_sat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge sysclk);
      if (i == 1) bus.data_valid = 1'b0;
      if (bus.out_valid === 1'b1) begin
        lat = i - 1;
        got = int'(bus.data_out);
        got_sat = int'(bus.sat);
        break;
      end
    end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_out"}, got, exp_out);
    check({tag, "_sat"}, got_sat, exp_sat);
  endtask

  int got, gs;
  int exp35[8] = '{812, 512, 512, 662, 512, 512, 587, 512};
  int exp36s[5] = '{0, 0, 1, 1, 1};
  int pulses;

  initial begin
    tests = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.data_in = '0;
    bus.data_valid = 1'b0;
    bus.delay = '0;
    bus.echo_en = 1'b0;
    @(negedge sysclk);
    do_reset();

    // Pass-through
    send("pass700", 700, 1, 0, got, gs);
    check("pass700_const", got, 700);
    // data_out holds between strobes
    repeat (3) @(negedge sysclk);
    check("hold_out", bus.data_out, 700);
    check("hold_valid_low", bus.out_valid, 0);

    // Decaying echo at delay 3
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send("echo3", (i == 0) ? 812 : 512, 3, 1, got, gs);
      check($sformatf("echo3_const%0d", i), got, exp35[i]);
    end

    // Clipping at delay 2
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send("clip2", 1023, 2, 1, got, gs);
      check($sformatf("clip2_out%0d", i), got, 1023);
      check($sformatf("clip2_sat%0d", i), gs, exp36s[i]);
    end

    // Full-depth delay (code 0): echo appears on the 17th sample only
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send("full", (i == 0) ? 600 : 512, 0, 1, got, gs);
      check($sformatf("full_const%0d", i), got, (i == 0) ? 600 : (i == 16) ? 556 : 512);
    end

    // Reset in CALC aborts the sample; stale RAM is not used afterwards
    do_reset();
    for (int i = 0; i < 3; i++) send("prefill", 900, 1, 0, got, gs);
    bus.data_in = 10'd1000;
    bus.delay = '0;
    bus.echo_en = 1'b1;
    bus.data_valid = 1'b1;
    @(negedge sysclk);
    bus.data_valid = 1'b0;
    @(negedge sysclk);  // DUT is now in CALC
    rst_n = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge sysclk);
      if (bus.out_valid === 1'b1) pulses++;
    end
    check("abort_no_valid", pulses, 0);
    check("abort_wr_ptr", dut.wr_ptr, 0);
    check("abort_fill", dut.fill, 0);
    check("abort_data_out", bus.data_out, 512);
    rst_n = 1'b1;
    hist.delete();
    @(negedge sysclk);
    send("after_abort", 512, 0, 1, got, gs);
    check("after_abort_const", got, 512);

    // Back-to-back strobes: the second is dropped
    bus.data_in = 10'd300;
    bus.delay = 4'd1;
    bus.echo_en = 1'b1;
    bus.data_valid = 1'b1;
    begin
      int eo, es;
      model_step(300, 1, 1, eo, es);
      pulses = 0;
      got = -1;
      gs = -1;
      for (int i = 1; i <= 8; i++) begin
        @(negedge sysclk);
        if (i == 2) bus.data_valid = 1'b0;
        if (bus.out_valid === 1'b1) begin
          pulses++;
          if (gs < 0) gs = i - 1;
          got = int'(bus.data_out);
        end
      end
      check("dbl_pulses", pulses, 1);
      check("dbl_latency", gs, 3);
      check("dbl_out", got, eo);
    end

    // Randomized samples
    do_reset();
    for (int i = 0; i < 80; i++) begin
      int din, dly, en;
      din = int'($urandom_range(0, 1023));
      dly = (i < 40) ? 3 : int'($urandom_range(0, 15));
      en = ($urandom_range(0, 3) != 0) ? 1 : 0;
      send($sformatf("rand%0d", i), din, dly, en, got, gs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
